// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - 5-stage pipeline hazard unit with multi-cycle execute interlock and perf counters
module hazard_unit_mc #(
    parameter int REG_AW    = 5,
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic [REG_AW-1:0] rsE,
    input  logic [REG_AW-1:0] rtE,
    input  logic [REG_AW-1:0] writeregE,
    input  logic [REG_AW-1:0] writeregM,
    input  logic [REG_AW-1:0] writeregW,
    input  logic              regwriteE,
    input  logic              regwriteM,
    input  logic              regwriteW,
    input  logic              memtoregE,
    input  logic              mc_opE,
    input  logic              pred_wrongM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mc_busy,
    output logic              mc_doneE,
    output logic [CNT_W-1:0]  lw_stall_cnt,
    output logic [CNT_W-1:0]  mc_stall_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int CB = $clog2(MC_CYCLES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // The IDLE issue cycle and the DONE cycle bracket the BUSY run, so BUSY lasts MC_CYCLES-2 cycles.
    localparam logic [CB-1:0] START_CNT = CB'(MC_CYCLES - 2);
    localparam logic [CB-1:0] ONE_CNT   = CB'(1);

    logic [1:0]    state;
    logic [1:0]    stateNext;
    logic [CB-1:0] cnt;
    logic [CB-1:0] cntNext;
    logic          lwStall;
    logic          mcStart;
    logic          mcStall;

    // E-stage operand forwarding; the younger M result wins over W.
    always_comb begin
        forwardAE = 2'b00;
        if (rsE != '0 && rsE == writeregM && regwriteM) begin
            forwardAE = 2'b10;
        end else if (rsE != '0 && rsE == writeregW && regwriteW) begin
            forwardAE = 2'b01;
        end
        forwardBE = 2'b00;
        if (rtE != '0 && rtE == writeregM && regwriteM) begin
            forwardBE = 2'b10;
        end else if (rtE != '0 && rtE == writeregW && regwriteW) begin
            forwardBE = 2'b01;
        end
    end

    // Load-use detection keyed on the load's destination register.
    always_comb begin
        lwStall = memtoregE && regwriteE && (writeregE != '0)
                  && ((rsD == writeregE) || (rtD == writeregE));
    end

    // Multi-cycle interlock: stall starts in the issue cycle, before the FSM leaves IDLE.
    always_comb begin
        mcStart = (state == IDLE) && mc_opE && !pred_wrongM;
        mcStall = mcStart || (state == BUSY);
    end

    // Pipeline control; flushes dominate stalls and a held E op keeps its E-reg.
    always_comb begin
        stallF   = mcStall || lwStall;
        stallD   = mcStall || lwStall;
        stallE   = mcStall;
        flushD   = pred_wrongM;
        flushE   = pred_wrongM || (lwStall && !mcStall);
        flushM   = pred_wrongM || mcStall;
        mc_busy  = (state == BUSY);
        mc_doneE = (state == DONE);
    end

    // Next-state logic for the multi-cycle occupancy FSM.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (mcStart) begin
                    stateNext = BUSY;
                    cntNext   = START_CNT;
                end
            end
            BUSY: begin
                if (pred_wrongM) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cnt <= ONE_CNT) begin
                    stateNext = DONE;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - ONE_CNT;
                end
            end
            DONE: begin
                // The op leaves E this cycle, so mc_opE here belongs to it and is ignored.
                stateNext = IDLE;
                cntNext   = '0;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // FSM state register; reset aborts any op in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            lw_stall_cnt <= '0;
            mc_stall_cnt <= '0;
            mispred_cnt  <= '0;
        end else begin
            if (lwStall && !mcStall && lw_stall_cnt != '1) begin
                lw_stall_cnt <= lw_stall_cnt + CNT_W'(1);
            end
            if (state == BUSY && mc_stall_cnt != '1) begin
                mc_stall_cnt <= mc_stall_cnt + CNT_W'(1);
            end
            if (pred_wrongM && mispred_cnt != '1) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;

    localparam int REG_AW = 5;
    localparam int MC     = 4;
    localparam int CNT_W  = 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic       sF;
        logic       sD;
        logic       sE;
        logic       fD;
        logic       fE;
        logic       fM;
        logic       busy;
        logic       done;
    } ctl_t;

    logic clk;
    logic rst;
    logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic regwriteE, regwriteM, regwriteW, memtoregE, mc_opE, pred_wrongM;
    logic [1:0] forwardAE, forwardBE;
    logic stallF, stallD, stallE, flushD, flushE, flushM, mc_busy, mc_doneE;
    logic [CNT_W-1:0] lw_stall_cnt, mc_stall_cnt, mispred_cnt;

    ctl_t act;
    assign act = {forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE, flushM, mc_busy, mc_doneE};

    int total = 0;
    int bad = 0;

    // Reference model: age of the multi-cycle op in E (0 = none), plus plain integer counters.
    int mAge = 0;
    int mLw = 0;
    int mMc = 0;
    int mMis = 0;

    hazard_unit_mc #(.REG_AW(REG_AW), .MC_CYCLES(MC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .mc_opE(mc_opE), .pred_wrongM(pred_wrongM),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .flushD(flushD), .flushE(flushE), .flushM(flushM),
        .mc_busy(mc_busy), .mc_doneE(mc_doneE),
        .lw_stall_cnt(lw_stall_cnt), .mc_stall_cnt(mc_stall_cnt), .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] fwd(input logic [REG_AW-1:0] src);
        if (src != 0 && src == writeregM && regwriteM) return 2'b10;
        if (src != 0 && src == writeregW && regwriteW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lw();
        return memtoregE && regwriteE && writeregE != 0 && (rsD == writeregE || rtD == writeregE);
    endfunction

    function automatic logic m_mc();
        return (mAge == 0 && mc_opE && !pred_wrongM) || (mAge >= 2 && mAge < MC);
    endfunction

    function automatic ctl_t model_ctl();
        ctl_t e;
        logic lw, mc;
        lw = m_lw();
        mc = m_mc();
        e.fa   = fwd(rsE);
        e.fb   = fwd(rtE);
        e.sF   = lw || mc;
        e.sD   = lw || mc;
        e.sE   = mc;
        e.fD   = pred_wrongM;
        e.fE   = pred_wrongM || (lw && !mc);
        e.fM   = pred_wrongM || mc;
        e.busy = (mAge >= 2 && mAge < MC);
        e.done = (mAge == MC);
        return e;
    endfunction

    // Advance the model with the inputs present at this edge, then move to just after the edge.
    task automatic tick();
        logic lw, mc;
        lw = m_lw();
        mc = m_mc();
        if (rst) begin
            mAge = 0; mLw = 0; mMc = 0; mMis = 0;
        end else begin
            if (lw && !mc && mLw < CMAX) mLw++;
            if (mAge >= 2 && mAge < MC && mMc < CMAX) mMc++;
            if (pred_wrongM && mMis < CMAX) mMis++;
            if (mAge == 0) mAge = (mc_opE && !pred_wrongM) ? 2 : 0;
            else if (mAge == MC) mAge = 0;
            else if (pred_wrongM) mAge = 0;
            else mAge = mAge + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 0; rtD = 0; rsE = 0; rtE = 0;
        writeregE = 0; writeregM = 0; writeregW = 0;
        regwriteE = 0; regwriteM = 0; regwriteW = 0;
        memtoregE = 0; mc_opE = 0; pred_wrongM = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if (act !== '0) begin
            bad++; $display("FAIL reset_ctl: got %h want 0", act);
        end
        total++;
        if ({lw_stall_cnt, mc_stall_cnt, mispred_cnt} !== '0) begin
            bad++; $display("FAIL reset_cnt: got %0d %0d %0d want 0 0 0", lw_stall_cnt, mc_stall_cnt, mispred_cnt);
        end
        tick();
    endtask

    task automatic test_forwarding();
        rsE = 8; rtE = 8; writeregM = 8; writeregW = 8; regwriteM = 1; regwriteW = 1;
        #1;
        total++;
        if (forwardAE !== 2'b10 || forwardBE !== 2'b10) begin
            bad++; $display("FAIL fwd_m_prio: got %b %b want 10 10", forwardAE, forwardBE);
        end
        regwriteM = 0;
        #1;
        total++;
        if (forwardAE !== 2'b01 || forwardBE !== 2'b01) begin
            bad++; $display("FAIL fwd_w: got %b %b want 01 01", forwardAE, forwardBE);
        end
        rsE = 0;
        #1;
        total++;
        if (forwardAE !== 2'b00 || forwardBE !== 2'b01) begin
            bad++; $display("FAIL fwd_zero_reg: got %b %b want 00 01", forwardAE, forwardBE);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        memtoregE = 1; regwriteE = 1; writeregE = 9; rtD = 9;
        #2;
        total++;
        if ({stallF, stallD, flushE, stallE} !== 4'b1110) begin
            bad++; $display("FAIL lw_ctl: got sF=%b sD=%b fE=%b sE=%b want 1 1 1 0", stallF, stallD, flushE, stallE);
        end
        tick();
        total++;
        if (lw_stall_cnt !== 3'd1) begin
            bad++; $display("FAIL lw_cnt: got %0d want 1", lw_stall_cnt);
        end
        writeregE = 0;
        #1;
        total++;
        if ({stallF, stallD, flushE} !== 3'b000) begin
            bad++; $display("FAIL lw_zero_reg: got sF=%b sD=%b fE=%b want 0 0 0", stallF, stallD, flushE);
        end
        tick();
        total++;
        if (lw_stall_cnt !== 3'd1) begin
            bad++; $display("FAIL lw_cnt_hold: got %0d want 1", lw_stall_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_multicycle();
        do_reset();
        mc_opE = 1;
        for (int c = 1; c <= MC; c++) begin
            #2;
            total++;
            if (c < MC) begin
                if ({stallF, stallD, stallE, flushM, mc_busy, mc_doneE} !== {4'b1111, (c >= 2), 1'b0}) begin
                    bad++; $display("FAIL mc_cycle%0d: got s=%b%b%b fM=%b busy=%b done=%b", c, stallF, stallD, stallE, flushM, mc_busy, mc_doneE);
                end
            end else begin
                if ({stallF, stallD, stallE, flushM, mc_busy, mc_doneE} !== 6'b000001) begin
                    bad++; $display("FAIL mc_done: got s=%b%b%b fM=%b busy=%b done=%b want 000 0 0 1", stallF, stallD, stallE, flushM, mc_busy, mc_doneE);
                end
                mc_opE = 0;
            end
            tick();
        end
        total++;
        if ({mc_busy, mc_doneE, stallE} !== 3'b000 || mc_stall_cnt !== 3'd2) begin
            bad++; $display("FAIL mc_after: got busy=%b done=%b sE=%b cnt=%0d want 0 0 0 2", mc_busy, mc_doneE, stallE, mc_stall_cnt);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        mc_opE = 1; pred_wrongM = 1;
        #2;
        total++;
        if ({flushD, flushE, flushM, stallF, stallD, stallE} !== 6'b111000) begin
            bad++; $display("FAIL mispred_ctl: got f=%b%b%b s=%b%b%b want 111 000", flushD, flushE, flushM, stallF, stallD, stallE);
        end
        tick();
        mc_opE = 0; pred_wrongM = 0;
        #1;
        total++;
        if ({mc_busy, mc_doneE} !== 2'b00 || mispred_cnt !== 3'd1) begin
            bad++; $display("FAIL mispred_after: got busy=%b done=%b cnt=%0d want 0 0 1", mc_busy, mc_doneE, mispred_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        mc_opE = 1;
        tick();
        tick();
        rst = 1;
        #1;
        total++;
        if (mc_busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_busy: got %b want 1", mc_busy);
        end
        tick();
        rst = 0; mc_opE = 0;
        #1;
        total++;
        if ({mc_busy, mc_doneE} !== 2'b00 || {lw_stall_cnt, mc_stall_cnt, mispred_cnt} !== '0) begin
            bad++; $display("FAIL rstmid_after: got busy=%b done=%b cnt=%0d/%0d/%0d want 0 0 0/0/0", mc_busy, mc_doneE, lw_stall_cnt, mc_stall_cnt, mispred_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        memtoregE = 1; regwriteE = 1; writeregE = 5; rsD = 5;
        for (int i = 1; i <= 10; i++) begin
            tick();
            total++;
            if (lw_stall_cnt !== CNT_W'((i < CMAX) ? i : CMAX)) begin
                bad++; $display("FAIL sat_cycle%0d: got %0d want %0d", i, lw_stall_cnt, (i < CMAX) ? i : CMAX);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        ctl_t e;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            rsD = REG_AW'($urandom_range(0, 3));
            rtD = REG_AW'($urandom_range(0, 3));
            rsE = REG_AW'($urandom_range(0, 3));
            rtE = REG_AW'($urandom_range(0, 3));
            writeregE = REG_AW'($urandom_range(0, 3));
            writeregM = REG_AW'($urandom_range(0, 3));
            writeregW = REG_AW'($urandom_range(0, 3));
            regwriteE = 1'($urandom);
            regwriteM = 1'($urandom);
            regwriteW = 1'($urandom);
            memtoregE = 1'($urandom);
            mc_opE = ($urandom_range(0, 2) != 0);
            pred_wrongM = ($urandom_range(0, 9) == 0);
            #2;
            e = model_ctl();
            total++;
            if (act !== e) begin
                bad++; $display("FAIL rand_ctl n=%0d: got %b want %b", n, act, e);
            end
            total++;
            if (lw_stall_cnt !== CNT_W'(mLw) || mc_stall_cnt !== CNT_W'(mMc) || mispred_cnt !== CNT_W'(mMis)) begin
                bad++; $display("FAIL rand_cnt n=%0d: got %0d/%0d/%0d want %0d/%0d/%0d", n, lw_stall_cnt, mc_stall_cnt, mispred_cnt, mLw, mMc, mMis);
            end
            tick();
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_mispredict();
        test_reset_mid_op();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
